change_dispenser: RTL and testbench

//  Downstream of parallel_subtractor: takes the change owed (diff) and borrow (bout) from credit - price.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/change_dispenser_coin_pick.sv | 30 +++
 rtl/change_dispenser.sv | 83 ++++++++
 tb/tb_change_dispenser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: FSM state encodings, coin select codes
// and coin denominations used by the dispenser, controller and acceptor.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    localparam logic [1:0] SEL_C = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_A = 2'd2;

    localparam int VEND_W = 4;
    localparam int DEN_A  = 5;
    localparam int DEN_B  = 2;
    // Smallest coin must be 1 so every amount is payable greedily.
    localparam int DEN_C  = 1;

endpackage

// File: rtl/change_dispenser_coin_pick.sv
// Greedy coin choice: largest denomination not exceeding the amount still owed.
module coin_pick
    import vend_pkg::*;
#(
    parameter int W     = VEND_W,
    parameter int DEN_A = vend_pkg::DEN_A,
    parameter int DEN_B = vend_pkg::DEN_B,
    parameter int DEN_C = vend_pkg::DEN_C
) (
    input  logic [W-1:0] remaining,
    output logic [1:0]   coin_sel,
    output logic [W-1:0] coin_value
);

    always_comb begin
        coin_sel   = SEL_C;
        coin_value = '0;
        if (remaining >= W'(DEN_A)) begin
            coin_sel   = SEL_A;
            coin_value = W'(DEN_A);
        end else if (remaining >= W'(DEN_B)) begin
            coin_sel   = SEL_B;
            coin_value = W'(DEN_B);
        end else if (remaining >= W'(DEN_C)) begin
            coin_sel   = SEL_C;
            coin_value = W'(DEN_C);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change owed one coin per valid/ack handshake, largest coin first,
// and reports done (payout complete) or err (underpaid start) as pulses.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int W     = VEND_W,
    parameter int DEN_A = vend_pkg::DEN_A,
    parameter int DEN_B = vend_pkg::DEN_B,
    parameter int DEN_C = vend_pkg::DEN_C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] diff,
    input  logic         bout,
    input  logic         coin_ack,
    output logic         coin_valid,
    output logic [1:0]   coin_sel,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] coin_cnt
);

    state_t       state;
    logic [W-1:0] remaining;
    logic [1:0]   pick_sel;
    logic [W-1:0] pick_val;

    coin_pick #(
        .W     (W),
        .DEN_A (DEN_A),
        .DEN_B (DEN_B),
        .DEN_C (DEN_C)
    ) u_pick (
        .remaining  (remaining),
        .coin_sel   (pick_sel),
        .coin_value (pick_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            coin_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (bout) begin
                            err <= 1'b1;
                        end else begin
                            remaining <= diff;
                            coin_cnt  <= '0;
                            state     <= (diff == '0) ? ST_DONE : ST_DISPENSE;
                        end
                    end
                end
                ST_DISPENSE: begin
                    if (coin_ack) begin
                        remaining <= remaining - pick_val;
                        if (coin_cnt != '1)
                            coin_cnt <= coin_cnt + W'(1);
                        // Last coin exactly clears the balance.
                        if (remaining == pick_val)
                            state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state flops, so they carry no input paths.
    assign coin_valid = (state == ST_DISPENSE);
    assign coin_sel   = coin_valid ? pick_sel : SEL_C;
    assign busy       = (state == ST_DISPENSE) || (state == ST_DONE);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser with directed corner cases.
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int W = 4;
    localparam int EV_COIN = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst, start, bout, coin_ack;
    logic [W-1:0] diff;
    logic         coin_valid, busy, done, err;
    logic [1:0]   coin_sel;
    logic [W-1:0] coin_cnt;

    ev_t  expq[$];
    ev_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   acc_cyc = 0;
    int   acc_count = 0;
    int   ack_mode = 0;
    int   ack_dly = 0;
    int   wcnt = 0;
    logic hold_prev = 1'b0;
    logic prev_valid = 1'b0;
    logic [1:0] prev_sel = 2'd0;

    change_dispenser #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .diff       (diff),
        .bout       (bout),
        .coin_ack   (coin_ack),
        .coin_valid (coin_valid),
        .coin_sel   (coin_sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .coin_cnt   (coin_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Reference: greedy payout computed as coin counts per denomination.
    task automatic push_expect(input int d, input bit b);
        int n5, n2, n1, r;
        if (b) begin
            expq.push_back('{EV_ERR, 0});
            return;
        end
        n5 = d / DEN_A;
        r  = d % DEN_A;
        n2 = r / DEN_B;
        n1 = r % DEN_B;
        repeat (n5) expq.push_back('{EV_COIN, 32'(SEL_A)});
        repeat (n2) expq.push_back('{EV_COIN, 32'(SEL_B)});
        repeat (n1) expq.push_back('{EV_COIN, 32'(SEL_C)});
        expq.push_back('{EV_DONE, n5 + n2 + n1});
    endtask

    // Ack generator: 0 = always ack, 1 = random, 2 = ack after ack_dly waiting cycles.
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: coin_ack = 1'b1;
            1: coin_ack = 1'($urandom % 2);
            default: begin
                if (coin_valid) begin
                    if (wcnt >= ack_dly) begin
                        coin_ack = 1'b1;
                        wcnt = 0;
                    end else begin
                        coin_ack = 1'b0;
                        wcnt++;
                    end
                end else begin
                    coin_ack = 1'b0;
                    wcnt = 0;
                end
            end
        endcase
    end

    // Monitor: pops the scoreboard on every accepted coin, done and err.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (coin_valid) begin
                check("busy_in_dispense", 32'(busy), 32'd1);
                if (hold_prev) check("sel_stable", 32'(coin_sel), 32'(prev_sel));
                if (!prev_valid) check("first_coin_latency", cyc, start_cyc + 1);
            end
            hold_prev  = coin_valid && !coin_ack;
            prev_valid = coin_valid;
            prev_sel   = coin_sel;
            if (coin_valid && coin_ack) begin
                acc_count++;
                acc_cyc = cyc;
                if (expq.size() == 0) fail_now("unexpected_coin");
                else begin
                    mon_e = expq.pop_front();
                    check("coin_event", mon_e.kind, EV_COIN);
                    check("coin_sel", 32'(coin_sel), mon_e.val);
                end
            end
            if (done) begin
                if (expq.size() == 0) fail_now("unexpected_done");
                else begin
                    mon_e = expq.pop_front();
                    check("done_event", mon_e.kind, EV_DONE);
                    check("coin_cnt", 32'(coin_cnt), mon_e.val);
                    check("busy_in_done", 32'(busy), 32'd1);
                    check("done_latency", cyc, (mon_e.val == 0) ? start_cyc + 1 : acc_cyc + 1);
                end
            end
            if (err) begin
                if (expq.size() == 0) fail_now("unexpected_err");
                else begin
                    mon_e = expq.pop_front();
                    check("err_event", mon_e.kind, EV_ERR);
                    check("err_latency", cyc, start_cyc + 1);
                    check("busy_on_err", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic issue(input int d, input bit b);
        @(posedge clk);
        #1;
        start     = 1'b1;
        diff      = W'(d);
        bout      = b;
        start_cyc = cyc;
        push_expect(d, b);
        @(posedge clk);
        #1;
        start = 1'b0;
        diff  = W'($urandom);
        bout  = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            fail_now("timeout_waiting_idle");
            expq.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_coin_valid"}, 32'(coin_valid), 32'd0);
        check({tag, "_coin_sel"},   32'(coin_sel),   32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_coin_cnt"},   32'(coin_cnt),   32'd0);
    endtask

    initial begin
        int n;
        int a0;
        rst = 1'b1; start = 1'b0; diff = '0; bout = 1'b0; coin_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // 1: 9 -> A,B,B with ack held high
        ack_mode = 0;
        issue(9, 1'b0);
        wait_idle();

        // 2: 3 -> B,C with slow acks
        ack_mode = 2; ack_dly = 4;
        issue(3, 1'b0);
        wait_idle();

        // 3: zero-change sale
        ack_mode = 0;
        issue(0, 1'b0);
        wait_idle();

        // 4: underpaid (wrapped diff) -> err only
        issue(12, 1'b1);
        wait_idle();
        check("idle_after_err", 32'(coin_valid), 32'd0);

        // 5: reset mid-payout, then a fresh single-coin payout
        ack_mode = 0;
        a0 = acc_count;
        issue(15, 1'b0);
        n = 0;
        while (acc_count == a0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("timeout_first_ack");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        expq.delete();
        @(posedge clk);
        #1;
        check("no_valid_in_rst", 32'(coin_valid), 32'd0);
        rst = 1'b0;
        issue(1, 1'b0);
        wait_idle();

        // 6: start during DISPENSE is ignored
        ack_mode = 2; ack_dly = 3;
        issue(5, 1'b0);
        start = 1'b1; diff = W'(9); bout = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Random transactions with mixed ack behaviour
        for (int i = 0; i < 40; i++) begin
            ack_mode = int'($urandom % 3);
            ack_dly  = int'($urandom % 4);
            issue(int'($urandom % 16), ($urandom % 5) == 0);
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        if (expq.size() != 0) fail_now("leftover_expectations");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
